// File: rtl/reg_arb.sv
// rtl/reg_arb.sv - two-port arbiter and access sequencer for the 16x8 register file
module reg_arb #(
   parameter bit FIXED_PRI = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       we0,
   input  logic       we1,
   input  logic [3:0] addr0,
   input  logic [3:0] addr1,
   input  logic [7:0] wdata0,
   input  logic [7:0] wdata1,
   output logic       ack0,
   output logic       ack1,
   output logic [7:0] rdata,
   output logic       busy,
   output logic       rf_write,
   output logic       rf_read,
   output logic [7:0] rf_addr,
   output logic [7:0] rf_in,
   input  logic [7:0] rf_data
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t     state, state_nx;
   logic       last;
   logic       port;
   logic       grant;
   logic       win;
   logic       sel_we;
   logic [3:0] sel_addr;
   logic [7:0] sel_wdata;

   logic       ack0_nx, ack1_nx, busy_nx, rf_write_nx, rf_read_nx;
   logic [7:0] rf_addr_nx, rf_in_nx, rdata_nx;

   // On a conflict the port not granted last wins, unless port 0 has fixed priority.
   always_comb begin
      grant = req0 | req1;
      if (req0 && req1)
         win = FIXED_PRI ? 1'b0 : ~last;
      else
         win = req1;
      sel_we    = win ? we1    : we0;
      sel_addr  = win ? addr1  : addr0;
      sel_wdata = win ? wdata1 : wdata0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (grant) state_nx = ACCESS;
         ACCESS:  state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Next values of the registered outputs; rf_addr/rf_in double as the latched request.
   always_comb begin
      ack0_nx     = (state == ACCESS) && !port;
      ack1_nx     = (state == ACCESS) && port;
      busy_nx     = (state_nx != IDLE);
      rf_write_nx = (state == IDLE) && grant && sel_we;
      rf_read_nx  = (state == IDLE) && grant && !sel_we;
      rf_addr_nx  = rf_addr;
      rf_in_nx    = rf_in;
      if (state == IDLE && grant) begin
         rf_addr_nx = {4'h0, sel_addr};
         rf_in_nx   = sel_wdata;
      end
      rdata_nx = (state == ACCESS && rf_read) ? rf_data : rdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         busy     <= 1'b0;
         rf_write <= 1'b0;
         rf_read  <= 1'b0;
         rf_addr  <= 8'h00;
         rf_in    <= 8'h00;
         rdata    <= 8'h00;
         last     <= 1'b1;
         port     <= 1'b0;
      end else begin
         ack0     <= ack0_nx;
         ack1     <= ack1_nx;
         busy     <= busy_nx;
         rf_write <= rf_write_nx;
         rf_read  <= rf_read_nx;
         rf_addr  <= rf_addr_nx;
         rf_in    <= rf_in_nx;
         rdata    <= rdata_nx;
         if (state == IDLE && grant) begin
            last <= win;
            port <= win;
         end
      end
   end

endmodule

// File: tb/tb_reg_arb.sv
// tb/tb_reg_arb.sv - self-checking bench for reg_arb (round-robin and fixed-priority instances)
module tb_reg_arb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tb_init = 1'b1;
   logic mon_on = 1'b0;
   always #5 clk = ~clk;

   logic       req0[2], req1[2], we0[2], we1[2];
   logic [3:0] addr0[2], addr1[2];
   logic [7:0] wdata0[2], wdata1[2];
   logic       ack0[2], ack1[2], busy[2], rf_write[2], rf_read[2];
   logic [7:0] rdata[2], rf_addr[2], rf_in[2], rf_data[2];
   logic [7:0] rf_mem[2][16];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      reg_arb #(.FIXED_PRI(g == 1)) u_dut (
         .clk(clk), .rst(rst),
         .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
         .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
         .ack0(ack0[g]), .ack1(ack1[g]), .rdata(rdata[g]), .busy(busy[g]),
         .rf_write(rf_write[g]), .rf_read(rf_read[g]), .rf_addr(rf_addr[g]),
         .rf_in(rf_in[g]), .rf_data(rf_data[g])
      );
      assign rf_data[g] = rf_read[g] ? rf_mem[g][rf_addr[g][3:0]] : 8'h00;
   end

   // Register file attached to each instance.
   always @(posedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (tb_init) begin
            for (int i = 0; i < 16; i++) rf_mem[g][i] <= 8'h30 + 8'(i);
         end else if (rf_write[g]) begin
            rf_mem[g][rf_addr[g][3:0]] <= rf_in[g];
         end
      end
   end

   // Reference model: one transaction in service at a time, each lasting
   // an access cycle then an ack cycle; m_left counts the cycles still owed.
   int         m_left[2];
   logic       m_port[2], m_we[2], m_last[2];
   logic [3:0] m_addr[2];
   logic [7:0] m_wdata[2], m_rdata[2];
   logic [7:0] m_mem[2][16];

   function automatic logic pick(int g);
      if (req0[g] && req1[g]) begin
         if (g == 1) return 1'b0;
         return (m_last[g] == 1'b1) ? 1'b0 : 1'b1;
      end
      return req1[g];
   endfunction

   always @(posedge clk or posedge rst) begin
      for (int g = 0; g < 2; g++) begin
         if (rst) begin
            m_left[g]  <= 0;
            m_last[g]  <= 1'b1;
            m_rdata[g] <= 8'h00;
            if (tb_init)
               for (int i = 0; i < 16; i++) m_mem[g][i] <= 8'h30 + 8'(i);
         end else if (m_left[g] == 0) begin
            if (req0[g] || req1[g]) begin
               m_port[g]  <= pick(g);
               m_last[g]  <= pick(g);
               m_we[g]    <= pick(g) ? we1[g] : we0[g];
               m_addr[g]  <= pick(g) ? addr1[g] : addr0[g];
               m_wdata[g] <= pick(g) ? wdata1[g] : wdata0[g];
               m_left[g]  <= 2;
            end
         end else if (m_left[g] == 2) begin
            if (m_we[g]) m_mem[g][m_addr[g]] <= m_wdata[g];
            else         m_rdata[g] <= m_mem[g][m_addr[g]];
            m_left[g] <= 1;
         end else begin
            m_left[g] <= 0;
         end
      end
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Requester driver: per requester (r = 2*instance + port) a queue of pending accesses.
   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
      int         gap;
   } item_t;

   item_t      q[4][$];
   int         ack_t[4][$];
   logic [7:0] ack_rd[4][$];
   int         age[4], gcnt[4];
   int         nwr[2], nrd[2];
   int         cyc = 0;

   function automatic logic get_req(int r);
      return (r % 2 == 1) ? req1[r / 2] : req0[r / 2];
   endfunction

   task automatic set_req(int r, logic v);
      if (r % 2 == 1) req1[r / 2] = v;
      else            req0[r / 2] = v;
   endtask

   task automatic load(int r, item_t it);
      int g;
      g = r / 2;
      if (r % 2 == 1) begin
         we1[g] = it.we; addr1[g] = it.addr; wdata1[g] = it.wdata;
      end else begin
         we0[g] = it.we; addr0[g] = it.addr; wdata0[g] = it.wdata;
      end
   endtask

   task automatic push(int r, logic we, logic [3:0] a, logic [7:0] d, int gap);
      item_t it;
      it.we = we; it.addr = a; it.wdata = d; it.gap = gap;
      q[r].push_back(it);
   endtask

   task automatic clear_all();
      for (int r = 0; r < 4; r++) begin
         set_req(r, 1'b0);
         q[r].delete(); ack_t[r].delete(); ack_rd[r].delete();
         age[r] = 0; gcnt[r] = 0;
      end
      nwr[0] = 0; nwr[1] = 0; nrd[0] = 0; nrd[1] = 0;
   endtask

   task automatic step();
      for (int g = 0; g < 2; g++) begin
         if (rf_write[g]) nwr[g]++;
         if (rf_read[g])  nrd[g]++;
      end
      for (int r = 0; r < 4; r++) begin
         logic a, dropped;
         item_t it;
         a = (r % 2 == 1) ? ack1[r / 2] : ack0[r / 2];
         dropped = 1'b0;
         if (a) begin
            chk($sformatf("ack only to a held req r%0d", r), int'(get_req(r)), 1);
            if (get_req(r)) begin
               ack_t[r].push_back(cyc);
               ack_rd[r].push_back(rdata[r / 2]);
               set_req(r, 1'b0);
               dropped = 1'b1;
               gcnt[r] = 0;
            end
         end else if (get_req(r)) begin
            age[r]++;
            if (age[r] > ((r < 2) ? 10 : 400)) begin
               n_cmp++; n_fail++;
               $display("FAIL ack wait r%0d: waited %0d cycles without ack", r, age[r]);
               set_req(r, 1'b0);
            end
         end
         if (!get_req(r) && !dropped && q[r].size() > 0) begin
            if (gcnt[r] < q[r][0].gap) begin
               gcnt[r]++;
            end else begin
               it = q[r].pop_front();
               load(r, it);
               set_req(r, 1'b1);
               age[r] = 0;
               gcnt[r] = 0;
            end
         end
      end
   endtask

   task automatic run(int maxc);
      for (int k = 0; k < maxc; k++) begin
         logic idle;
         @(negedge clk);
         cyc++;
         step();
         idle = 1'b1;
         for (int r = 0; r < 4; r++)
            if (q[r].size() > 0 || get_req(r)) idle = 1'b0;
         if (idle) return;
      end
      n_cmp++; n_fail++;
      $display("FAIL run timeout: traffic still pending after %0d cycles", maxc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      clear_all();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int t0;
      for (int g = 0; g < 2; g++) begin
         req0[g] = 0; req1[g] = 0; we0[g] = 0; we1[g] = 0;
         addr0[g] = 0; addr1[g] = 0; wdata0[g] = 0; wdata1[g] = 0;
      end
      clear_all();
      @(negedge clk);
      @(negedge clk);
      tb_init = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      mon_on = 1'b1;

      // Per-cycle comparison against the model, sampled away from the clock edge.
      fork
         forever begin
            @(posedge clk);
            #2;
            if (!rst && mon_on) begin
               for (int g = 0; g < 2; g++) begin
                  chk($sformatf("i%0d ack0", g), int'(ack0[g]), int'(m_left[g] == 1 && !m_port[g]));
                  chk($sformatf("i%0d ack1", g), int'(ack1[g]), int'(m_left[g] == 1 && m_port[g]));
                  chk($sformatf("i%0d busy", g), int'(busy[g]), int'(m_left[g] != 0));
                  chk($sformatf("i%0d rf_write", g), int'(rf_write[g]), int'(m_left[g] == 2 && m_we[g]));
                  chk($sformatf("i%0d rf_read", g), int'(rf_read[g]), int'(m_left[g] == 2 && !m_we[g]));
                  chk($sformatf("i%0d rdata", g), int'(rdata[g]), int'(m_rdata[g]));
                  if (m_left[g] == 2) begin
                     chk($sformatf("i%0d rf_addr", g), int'(rf_addr[g]), int'({4'h0, m_addr[g]}));
                     if (m_we[g]) chk($sformatf("i%0d rf_in", g), int'(rf_in[g]), int'(m_wdata[g]));
                  end
               end
            end
         end
      join_none

      // Reset values
      for (int g = 0; g < 2; g++) begin
         chk("reset ack0", int'(ack0[g]), 0);
         chk("reset ack1", int'(ack1[g]), 0);
         chk("reset busy", int'(busy[g]), 0);
         chk("reset rf_write", int'(rf_write[g]), 0);
         chk("reset rf_read", int'(rf_read[g]), 0);
         chk("reset rdata", int'(rdata[g]), 8'h00);
         chk("reset rf_addr", int'(rf_addr[g]), 8'h00);
         chk("reset rf_in", int'(rf_in[g]), 8'h00);
      end

      // Single write then read on the round-robin instance
      t0 = cyc + 1;
      push(0, 1'b1, 4'd3, 8'hA5, 0);
      push(0, 1'b0, 4'd3, 8'h00, 0);
      run(50);
      chk("write ack latency", ack_t[0][0] - t0, 2);
      chk("read ack latency", ack_t[0][1] - t0, 5);
      chk("read data", int'(ack_rd[0][1]), 8'hA5);
      chk("write cycles", nwr[0], 1);
      chk("read cycles", nrd[0], 1);
      chk("rf contents addr3", int'(rf_mem[0][3]), 8'hA5);

      // Round-robin conflict from reset: port 0 first, then port 1 over port 0's new request
      do_reset();
      t0 = cyc + 1;
      push(0, 1'b1, 4'd5, 8'h11, 0);
      push(0, 1'b0, 4'd5, 8'h00, 0);
      push(1, 1'b0, 4'd5, 8'h00, 0);
      run(50);
      chk("rr first ack0", ack_t[0][0] - t0, 2);
      chk("rr ack1", ack_t[1][0] - t0, 5);
      chk("rr ack1 rdata", int'(ack_rd[1][0]), 8'h11);
      chk("rr second ack0", ack_t[0][1] - t0, 8);
      chk("rr second ack0 rdata", int'(ack_rd[0][1]), 8'h11);

      // Fixed priority: port 0 keeps re-requesting, port 1 waits until it stops
      do_reset();
      t0 = cyc + 1;
      push(2, 1'b1, 4'd1, 8'h0A, 0);
      push(2, 1'b1, 4'd1, 8'h0B, 0);
      push(2, 1'b1, 4'd1, 8'h0C, 0);
      push(3, 1'b0, 4'd1, 8'h00, 0);
      run(60);
      chk("fp ack0 #1", ack_t[2][0] - t0, 2);
      chk("fp ack0 #2", ack_t[2][1] - t0, 5);
      chk("fp ack0 #3", ack_t[2][2] - t0, 8);
      chk("fp ack1", ack_t[3][0] - t0, 11);
      chk("fp ack1 rdata", int'(ack_rd[3][0]), 8'h0C);

      // Reset during a port-1 write access
      do_reset();
      @(negedge clk);
      we1[0] = 1'b1; addr1[0] = 4'd7; wdata1[0] = 8'hFF; req1[0] = 1'b1;
      @(negedge clk);
      chk("abort write in access", int'(rf_write[0]), 1);
      chk("abort addr in access", int'(rf_addr[0]), 8'h07);
      rst = 1'b1;
      #1;
      chk("abort rf_write async", int'(rf_write[0]), 0);
      chk("abort busy async", int'(busy[0]), 0);
      chk("abort ack1", int'(ack1[0]), 0);
      req1[0] = 1'b0;
      @(negedge clk);
      chk("abort ack1 held", int'(ack1[0]), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort no ack1 after", int'(ack1[0]), 0);
      clear_all();
      push(1, 1'b0, 4'd7, 8'h00, 0);
      run(50);
      chk("abort read prior value", int'(ack_rd[1][0]), 8'h37);
      chk("abort rf untouched", int'(rf_mem[0][7]), 8'h37);

      // Random traffic on both instances
      do_reset();
      for (int r = 0; r < 4; r++)
         for (int k = 0; k < 110; k++)
            push(r, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), int'($urandom_range(0, 4)));
      run(4000);
      for (int r = 0; r < 4; r++)
         chk($sformatf("random ack count r%0d", r), ack_t[r].size(), 110);

      mon_on = 1'b0;
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
